enemy_spawn_sched: RTL and testbench
====================================

ENEMY_SPAWN_SCHED -- requirements
Module: enemy_spawn_sched

Interface
REQ-001 Parameter SLOT_NUM, default 4, number of enemy slots scheduled.
REQ-002 Parameter IDX_W, default 2, slot index width (clog2 of SLOT_NUM).
REQ-003 Parameter INTERVAL_BASE, default 60, frames between spawn attempts at level 0.
REQ-004 Parameter X_MAX, default 583, exclusive upper bound of spawn x (640 minus enemy width).
REQ-005 Parameter LFSR_SEED, default 16'hACE1, LFSR reset value; non-zero.
REQ-006 Clocking: one clock; reset is asynchronous and active-low.
REQ-007 clk_run  input  1  game-logic clock; all state on rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 en_i  input  1  scheduler enable (game running).
REQ-010 frame_tick_i  input  1  one-cycle pulse per video frame.
REQ-011 level_i  input  2  difficulty level 0..3.
REQ-012 slot_busy_i  input  SLOT_NUM  bit i high = slot i visible/occupied.
REQ-013 spawn_ready_i  input  1  enemy bank accepts a spawn command.
REQ-014 spawn_valid_o  output  1  spawn command valid.
REQ-015 spawn_idx_o  output  IDX_W  target slot.
REQ-016 spawn_x_o  output  10  spawn x position, 0..X_MAX-1.
REQ-017 spawn_speed_o  output  2  speed code: 01 low, 11 middle, 10 high.
REQ-018 spawn_drop_o  output  1  one-cycle pulse: attempt dropped, no free slot.

Function
REQ-019 FSM states IDLE, WAIT, PICK, ISSUE.
REQ-020 IDLE: outputs inactive; en_i high -> WAIT, frame counter loaded with interval.
REQ-021 interval = INTERVAL_BASE >> level_i, sampled when counter reloads; minimum 1.
REQ-022 WAIT: counter decrements on each frame_tick_i; tick with counter==1 -> PICK next cycle.
REQ-023 PICK (one cycle): round-robin search from rr_ptr upward with wrap for first slot with slot_busy_i bit low.
REQ-024 PICK with free slot: latch idx, x, speed; -> ISSUE; spawn_valid_o high the cycle after PICK.
REQ-025 PICK with all slots busy: spawn_drop_o pulses 1 cycle, counter reloaded, -> WAIT; rr_ptr unchanged.
REQ-026 ISSUE: spawn_valid_o and payload held stable until spawn_valid_o && spawn_ready_i; no retraction.
REQ-027 Transfer cycle: rr_ptr <= idx+1 mod SLOT_NUM, counter reloaded, -> WAIT (-> IDLE if en_i low).
REQ-028 en_i low in WAIT or PICK: -> IDLE next cycle, no spawn, no drop pulse.
REQ-029 en_i low in ISSUE: handshake completes first, then IDLE.
REQ-030 frame_tick_i ignored outside WAIT; ticks during ISSUE stall are not accumulated.
REQ-031 LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every cycle regardless of state.
REQ-032 x = lfsr[9:0]; if >= X_MAX then x - X_MAX; single conditional subtract, result always < X_MAX.
REQ-033 Speed: level 0 -> 01; level 1 -> lfsr[10] ? 11 : 01; level 2/3 -> lfsr[11:10]==00 ? 10 : (lfsr[10] ? 11 : 01).
REQ-034 Code 00 (stop) is never emitted.
REQ-035 slot_busy_i sampled only in PICK; changes during ISSUE do not alter latched idx.

Reset
REQ-036 rst_n low: state IDLE, rr_ptr 0, counter 0, lfsr LFSR_SEED, all outputs 0; effective asynchronously.
REQ-037 Reset mid-ISSUE drops the pending command; spawn_valid_o low immediately.

Verification
REQ-038 level 0, INTERVAL_BASE=4, slots free, ready high: spawn_valid_o one cycle, 2 cycles after 4th tick, idx 0, then 1,2,3,0.
REQ-039 slot_busy_i=4'b1111 at PICK: spawn_drop_o one pulse, no valid, next attempt 4 ticks later; rr_ptr unchanged.
REQ-040 rr_ptr=2, slot_busy_i=4'b1100: idx 0 chosen (wrap).
REQ-041 spawn_ready_i low 10 cycles: valid/idx/x/speed constant, ticks ignored, transfer on ready, reload afterward.
REQ-042 10k spawns, level 0..3 swept: x always < 583, speed never 00, level 0 always 01, level 3 interval 7 frames.
REQ-043 rst_n low during ISSUE: valid low asynchronously; after release, IDLE and lfsr = 16'hACE1.

Source files
------------

// File: rtl/enemy_spawn_sched.sv
// Enemy spawn scheduler. Every N frames it picks a free enemy slot round-robin and
// issues a valid/ready spawn command with an LFSR-derived x position and speed.
module enemy_spawn_sched #(
    parameter int          SLOT_NUM      = 4,
    parameter int          IDX_W         = 2,
    parameter int          INTERVAL_BASE = 60,
    parameter int          X_MAX         = 583,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                clk_run,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                frame_tick_i,
    input  logic [1:0]          level_i,
    input  logic [SLOT_NUM-1:0] slot_busy_i,
    input  logic                spawn_ready_i,
    output logic                spawn_valid_o,
    output logic [IDX_W-1:0]    spawn_idx_o,
    output logic [9:0]          spawn_x_o,
    output logic [1:0]          spawn_speed_o,
    output logic                spawn_drop_o
);
    localparam int CNT_W = (INTERVAL_BASE < 2) ? 1 : $clog2(INTERVAL_BASE + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PICK, S_ISSUE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [9:0]         x_q, x_d;
    logic [1:0]         speed_q, speed_d;
    logic               drop_q, drop_d;
    logic [15:0]        lfsr_q;

    logic [CNT_W-1:0]   interval;
    logic               found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   idx_next;
    logic [9:0]         x_new;
    logic [1:0]         speed_new;

    // Reload value; deep levels on a small base must never yield a zero-length interval.
    always_comb begin
        interval = CNT_W'(INTERVAL_BASE) >> level_i;
        if (interval == '0) begin
            interval = CNT_W'(1);
        end
    end

    // Round-robin search: walk downward so the slot closest to rr_q wins.
    always_comb begin
        int s;
        found    = 1'b0;
        pick_idx = rr_q;
        for (int k = SLOT_NUM - 1; k >= 0; k--) begin
            s = int'(rr_q) + k;
            if (s >= SLOT_NUM) begin
                s = s - SLOT_NUM;
            end
            if (!slot_busy_i[s]) begin
                found    = 1'b1;
                pick_idx = IDX_W'(s);
            end
        end
    end

    assign idx_next = (int'(idx_q) == SLOT_NUM - 1) ? '0 : idx_q + IDX_W'(1);
    assign x_new    = (lfsr_q[9:0] >= 10'(X_MAX)) ? lfsr_q[9:0] - 10'(X_MAX) : lfsr_q[9:0];

    always_comb begin
        speed_new = 2'b01;
        if (level_i == 2'd1) begin
            speed_new = lfsr_q[10] ? 2'b11 : 2'b01;
        end else if (level_i[1]) begin
            if (lfsr_q[11:10] == 2'b00) begin
                speed_new = 2'b10;
            end else begin
                speed_new = lfsr_q[10] ? 2'b11 : 2'b01;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        idx_d   = idx_q;
        x_d     = x_q;
        speed_d = speed_q;
        drop_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en_i) begin
                    state_d = S_WAIT;
                    cnt_d   = interval;
                end
            end
            S_WAIT: begin
                if (!en_i) begin
                    state_d = S_IDLE;
                end else if (frame_tick_i) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = S_PICK;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_PICK: begin
                if (!en_i) begin
                    state_d = S_IDLE;
                end else if (found) begin
                    idx_d   = pick_idx;
                    x_d     = x_new;
                    speed_d = speed_new;
                    state_d = S_ISSUE;
                end else begin
                    drop_d  = 1'b1;
                    cnt_d   = interval;
                    state_d = S_WAIT;
                end
            end
            S_ISSUE: begin
                // The command is never retracted, even if the game stops meanwhile.
                if (spawn_ready_i) begin
                    rr_d    = idx_next;
                    cnt_d   = interval;
                    state_d = en_i ? S_WAIT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_run or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rr_q    <= '0;
            idx_q   <= '0;
            x_q     <= '0;
            speed_q <= '0;
            drop_q  <= 1'b0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            speed_q <= speed_d;
            drop_q  <= drop_d;
            // Galois form of x^16+x^14+x^13+x^11+1, free-running
            lfsr_q  <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign spawn_valid_o = (state_q == S_ISSUE);
    assign spawn_idx_o   = idx_q;
    assign spawn_x_o     = x_q;
    assign spawn_speed_o = speed_q;
    assign spawn_drop_o  = drop_q;

endmodule

// File: tb/tb_enemy_spawn_sched.sv
// Bench for enemy_spawn_sched: transaction-level reference model of interval,
// round-robin slot choice, LFSR-derived x/speed and the valid/ready handshake.
module tb_enemy_spawn_sched;
    localparam int BASE = 60;
    localparam int XMAX = 583;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       frame_tick;
    logic [1:0] level;
    logic [3:0] slot_busy;
    logic       spawn_ready;
    logic       valid;
    logic [1:0] idx;
    logic [9:0] x;
    logic [1:0] speed;
    logic       drop;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_interval;
    int rr_m;
    logic [15:0] lfsr_m, lfsr_prev, tap_mask;

    enemy_spawn_sched dut (
        .clk_run(clk), .rst_n(rst_n), .en_i(en), .frame_tick_i(frame_tick),
        .level_i(level), .slot_busy_i(slot_busy), .spawn_ready_i(spawn_ready),
        .spawn_valid_o(valid), .spawn_idx_o(idx), .spawn_x_o(x),
        .spawn_speed_o(speed), .spawn_drop_o(drop)
    );

    always #5 clk = ~clk;

    // Tap mask built from the polynomial exponents 16,14,13,11.
    initial begin
        int taps[4] = '{16, 14, 13, 11};
        tap_mask = '0;
        foreach (taps[t]) tap_mask[taps[t]-1] = 1'b1;
    end

    // lfsr_prev is the value held during the cycle before the latest edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_m    <= 16'hACE1;
            lfsr_prev <= 16'hACE1;
        end else begin
            lfsr_prev <= lfsr_m;
            lfsr_m    <= (lfsr_m >> 1) ^ (lfsr_m[0] ? tap_mask : 16'h0);
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int ival(input logic [1:0] l);
        int v = BASE >> l;
        return (v < 1) ? 1 : v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_attempt(input logic [3:0] bsy, input logic [1:0] nxt,
                              input int stall, input bit en_off);
        int got_nt = 0;
        int exp_idx = -1;
        int ex_x;
        logic [1:0] ex_spd;
        logic [15:0] l;
        slot_busy   = bsy;
        spawn_ready = (stall == 0);
        for (int k = 3; k >= 0; k--)
            if (!bsy[(rr_m + k) % 4]) exp_idx = (rr_m + k) % 4;
        for (int nt = 1; nt <= exp_interval + 1; nt++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            if (nt == exp_interval) level = nxt;
            n_cmp++;
            if (valid !== 1'b0 || drop !== 1'b0) begin
                n_bad++;
                $display("FAIL early_output tick %0d: valid=%b drop=%b, required 0/0", nt, valid, drop);
            end
            cyc();
            if (valid === 1'b1 || drop === 1'b1) begin
                got_nt = nt;
                break;
            end
        end
        n_cmp++;
        if (got_nt != exp_interval) begin
            n_bad++;
            $display("FAIL interval: attempt after %0d ticks, required %0d", got_nt, exp_interval);
        end
        if (got_nt == 0) begin
            spawn_ready = 1'b1;
            return;
        end
        l = lfsr_prev;
        if (exp_idx < 0) begin
            n_cmp++;
            if (drop !== 1'b1 || valid !== 1'b0) begin
                n_bad++;
                $display("FAIL drop_pulse: drop=%b valid=%b, required 1/0", drop, valid);
            end
            cyc();
            n_cmp++;
            if (drop !== 1'b0 || valid !== 1'b0) begin
                n_bad++;
                $display("FAIL drop_single: drop=%b valid=%b, required 0/0", drop, valid);
            end
            exp_interval = ival(nxt);
            $display("attempt: busy=%b level=%0d -> dropped", bsy, nxt);
            return;
        end
        ex_x = int'(l[9:0]);
        if (ex_x >= XMAX) ex_x -= XMAX;
        if (nxt >= 2 && !l[10] && !l[11]) ex_spd = 2'b10;
        else if (nxt >= 1 && l[10])       ex_spd = 2'b11;
        else                              ex_spd = 2'b01;
        n_cmp++;
        if (valid !== 1'b1 || drop !== 1'b0 || idx !== 2'(exp_idx) || x !== 10'(ex_x) || speed !== ex_spd) begin
            n_bad++;
            $display("FAIL spawn_cmd: valid=%b drop=%b idx=%0d x=%0d spd=%b, required 1/0 idx=%0d x=%0d spd=%b",
                     valid, drop, idx, x, speed, exp_idx, ex_x, ex_spd);
        end
        n_cmp++;
        if (!(int'(x) < XMAX) || speed === 2'b00) begin
            n_bad++;
            $display("FAIL range: x=%0d speed=%b, required x<%0d and speed!=00", x, speed, XMAX);
        end
        for (int s = 0; s < stall; s++) begin
            frame_tick = 1'($urandom_range(0, 1));
            slot_busy  = 4'($urandom);
            if (en_off) en = 1'b0;
            cyc();
            frame_tick = 1'b0;
            n_cmp++;
            if (valid !== 1'b1 || idx !== 2'(exp_idx) || x !== 10'(ex_x) || speed !== ex_spd) begin
                n_bad++;
                $display("FAIL stall_hold cyc %0d: valid=%b idx=%0d x=%0d spd=%b, required 1 idx=%0d x=%0d spd=%b",
                         s, valid, idx, x, speed, exp_idx, ex_x, ex_spd);
            end
        end
        spawn_ready = 1'b1;
        cyc();
        n_cmp++;
        if (valid !== 1'b0) begin
            n_bad++;
            $display("FAIL after_transfer: valid=%b, required 0", valid);
        end
        rr_m = (exp_idx + 1) % 4;
        exp_interval = ival(nxt);
        $display("attempt: busy=%b level=%0d stall=%0d -> idx=%0d x=%0d speed=%b", bsy, nxt, stall, idx, ex_x, ex_spd);
    endtask

    task automatic check_quiet(input string name, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            n_cmp++;
            if (valid !== 1'b0 || drop !== 1'b0) begin
                n_bad++;
                $display("FAIL %s: valid=%b drop=%b, required 0/0", name, valid, drop);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; frame_tick = 1'b0; level = 2'd0;
        slot_busy = 4'h0; spawn_ready = 1'b1;
        #23;
        n_cmp++;
        if (valid !== 1'b0 || idx !== 2'd0 || x !== 10'd0 || speed !== 2'd0 || drop !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: v=%b i=%0d x=%0d s=%b d=%b, required all 0", valid, idx, x, speed, drop);
        end
        rst_n = 1'b1;
        rr_m = 0;
        check_quiet("idle_quiet", 3);
        $display("reset: outputs checked");
    endtask

    task automatic test_basic_rr();
        level = 2'd0; en = 1'b1;
        cyc();
        exp_interval = ival(2'd0);
        for (int i = 0; i < 5; i++) do_attempt(4'h0, 2'd0, 0, 1'b0);
    endtask

    task automatic test_all_busy();
        do_attempt(4'hF, 2'd3, 0, 1'b0);
        do_attempt(4'h0, 2'd3, 0, 1'b0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4 && rr_m != 2; i++) do_attempt(4'h0, 2'd3, 0, 1'b0);
        do_attempt(4'b1100, 2'd3, 0, 1'b0);
    endtask

    task automatic test_stall();
        do_attempt(4'h0, 2'd3, 10, 1'b0);
        do_attempt(4'h0, 2'd3, 10, 1'b1);
        check_quiet("idle_after_issue", 4);
        level = 2'd3; en = 1'b1;
        cyc();
        exp_interval = ival(2'd3);
        do_attempt(4'h0, 2'd3, 0, 1'b0);
    endtask

    task automatic test_disable();
        for (int t = 0; t < 3; t++) begin
            frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
        end
        en = 1'b0;
        check_quiet("disable_wait", 3);
        level = 2'd2; en = 1'b1;
        cyc();
        exp_interval = ival(2'd2);
        do_attempt(4'h0, 2'd3, 0, 1'b0);
        for (int nt = 1; nt <= exp_interval; nt++) begin
            frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
            if (nt < exp_interval) cyc();
        end
        en = 1'b0;
        check_quiet("disable_pick", 3);
        level = 2'd3; en = 1'b1;
        cyc();
        exp_interval = ival(2'd3);
        do_attempt(4'h0, 2'd3, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] bsy;
        for (int i = 0; i < 300; i++) begin
            bsy = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom);
            do_attempt(bsy, 2'($urandom_range(0, 3)), $urandom_range(0, 3), 1'b0);
        end
    endtask

    task automatic test_reset_issue();
        int seen = 0;
        slot_busy = 4'h0; spawn_ready = 1'b0;
        for (int nt = 0; nt <= exp_interval + 1 && seen == 0; nt++) begin
            frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
            if (valid === 1'b1) seen = 1;
        end
        n_cmp++;
        if (seen != 1) begin
            n_bad++;
            $display("FAIL reset_issue_setup: valid never rose, required 1");
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (valid !== 1'b0 || idx !== 2'd0 || x !== 10'd0 || speed !== 2'd0 || drop !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: v=%b i=%0d x=%0d s=%b d=%b, required all 0", valid, idx, x, speed, drop);
        end
        en = 1'b0;
        #20 rst_n = 1'b1;
        rr_m = 0;
        check_quiet("idle_after_reset", 2);
        level = 2'd3; en = 1'b1;
        cyc();
        exp_interval = ival(2'd3);
        do_attempt(4'h0, 2'd3, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_rr();
        test_all_busy();
        test_wrap();
        test_stall();
        test_disable();
        test_random();
        test_reset_issue();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
